playseq_controle_preview: RTL
=============================

// Module: playseq_controle_preview
// PURPOSE
//  Sequences the LED preview phase of PlaySeq: walks the sequence RAM from address 0 up to a
//  captured limit, lights each stored move on the LEDs for a fixed time, then blanks them.
//  Sits between the UC (start/abort/done handshake) and the FD (RAM address, LED drive).
//  Replaces the UC's ad-hoc preview timer states with one self-contained sequencer.
// PARAMETERS
//  ADDR_W      4    RAM address width
//  DATA_W      4    RAM word width (one-hot move, one bit per LED)
//  ON_CYCLES   500  clocks a move stays lit (>=1)
//  OFF_CYCLES  250  clocks LEDs stay dark between moves (>=1)
//  CNT_W       16   timer width; must hold max(ON_CYCLES,OFF_CYCLES)
// PORTS
//  clock      in   1       system clock, rising edge
//  reset      in   1       synchronous, active-high
//  iniciar    in   1       start pulse from UC; sampled only in OCIOSO
//  parar      in   1       abort; sampled in every state
//  limite     in   ADDR_W  last address to show (current sequence length-1)
//  dado_mem   in   DATA_W  RAM read data; valid 1 clock after endereco changes
//  endereco   out  ADDR_W  RAM read address (registered)
//  leds       out  DATA_W  LED drive (registered)
//  ativo      out  1       high while a preview is in progress (any state but OCIOSO)
//  pronto     out  1       1-clock pulse: preview finished normally
//  db_estado  out  3       current state code, for hex display
// BEHAVIOUR
//  Reset (sync): state=OCIOSO, endereco=0, leds=0, ativo=0, pronto=0, timer=0, limite_reg=0.
//  States (code): OCIOSO(0) CARREGA(1) ACESO(2) APAGADO(3) FIM(4); codes 5-7 -> OCIOSO.
//  OCIOSO : iniciar=1 & parar=0 -> capture limite into limite_reg, endereco<=0, -> CARREGA.
//  CARREGA: exactly 1 clock (RAM latency); on exit leds<=dado_mem, timer<=0, -> ACESO.
//  ACESO  : leds held; timer counts; after exactly ON_CYCLES clocks in state: leds<=0,
//           timer<=0, -> APAGADO.
//  APAGADO: leds=0; after exactly OFF_CYCLES clocks: if endereco==limite_reg -> FIM,
//           else endereco<=endereco+1 -> CARREGA.
//  FIM    : pronto=1 for this single clock; endereco<=0; -> OCIOSO.
//  Timing : moves shown = limite_reg+1; iniciar edge to FIM entry =
//           (limite_reg+1)*(1+ON_CYCLES+OFF_CYCLES) clocks.
//  limite changes after capture are ignored; limite=2^ADDR_W-1 shows all words, endereco
//  never wraps past limite_reg.
//  iniciar outside OCIOSO ignored (no restart). parar in any non-OCIOSO state: next edge
//  -> OCIOSO, leds=0, endereco=0, no pronto. parar+iniciar same clock in OCIOSO: stay idle.
//  parar has priority over timer expiry and the FIM transition (pronto suppressed only if
//  parar arrives before FIM is entered; the FIM pulse itself is never cut short).
//  reset mid-operation behaves as parar plus full register clear.
//  No combinational path from any input to any output.
// TESTING (ON_CYCLES=3, OFF_CYCLES=2, so 6 clocks per move)
//  1 Reset: hold reset 2 clocks -> leds=0, endereco=0, ativo=0, pronto=0, db_estado=0.
//  2 RAM={1,2,4,8}, limite=3, iniciar pulse -> leds 1,2,4,8 each lit 3 clocks, dark 2;
//    pronto pulses once 24 clocks after iniciar; ativo low next clock.
//  3 limite=0, RAM[0]=4 -> single move 4 lit 3 clocks; pronto 6 clocks after iniciar.
//  4 Start limite=3, change limite to 1 and pulse iniciar mid-run -> still 4 moves shown,
//    single pronto at clock 24.
//  5 parar during 2nd move's ACESO -> next clock leds=0, endereco=0, ativo=0; no pronto.
//  6 parar=1 & iniciar=1 in OCIOSO -> remains OCIOSO; then limite=15 full run -> endereco
//    reaches 15, no wrap; pronto at clock 96.

Source files
------------

// File: rtl/playseq_controle_preview_if.sv
// Bus between the PlaySeq UC/FD and the preview sequencer.
// The master side drives the control inputs and RAM data; the slave side is the sequencer.
interface playseq_controle_preview_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);
  logic              iniciar;
  logic              parar;
  logic [ADDR_W-1:0] limite;
  logic [DATA_W-1:0] dado_mem;
  logic [ADDR_W-1:0] endereco;
  logic [DATA_W-1:0] leds;
  logic              ativo;
  logic              pronto;
  logic [2:0]        db_estado;

  modport master (
    output iniciar, parar, limite, dado_mem,
    input  endereco, leds, ativo, pronto, db_estado
  );

  modport slave (
    input  iniciar, parar, limite, dado_mem,
    output endereco, leds, ativo, pronto, db_estado
  );
endinterface

// File: rtl/playseq_controle_preview.sv
// LED preview sequencer for PlaySeq: walks the sequence RAM from address 0 to a captured limit,
// lighting each stored move for ON_CYCLES clocks and blanking for OFF_CYCLES clocks.
module playseq_controle_preview #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 4,
  parameter int ON_CYCLES  = 500,
  parameter int OFF_CYCLES = 250,
  parameter int CNT_W      = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  playseq_controle_preview_if.slave  bus
);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACESO   = 3'd2,
    APAGADO = 3'd3,
    FIM     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_timer;
  logic [ADDR_W-1:0] r_limite;
  logic [ADDR_W-1:0] r_endereco;
  logic [DATA_W-1:0] r_leds;
  logic              r_ativo;
  logic              r_pronto;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= OCIOSO;
      r_timer    <= '0;
      r_limite   <= '0;
      r_endereco <= '0;
      r_leds     <= '0;
      r_ativo    <= 1'b0;
      r_pronto   <= 1'b0;
    end else begin
      r_pronto <= 1'b0;
      // Abort wins over every other transition, including timer expiry and entry into FIM.
      if (bus.parar && (r_state != OCIOSO)) begin
        r_state    <= OCIOSO;
        r_timer    <= '0;
        r_endereco <= '0;
        r_leds     <= '0;
        r_ativo    <= 1'b0;
      end else begin
        case (r_state)
          OCIOSO: begin
            if (bus.iniciar && !bus.parar) begin
              r_limite   <= bus.limite;
              r_endereco <= '0;
              r_timer    <= '0;
              r_state    <= CARREGA;
              r_ativo    <= 1'b1;
            end
          end
          CARREGA: begin
            // The RAM word for r_endereco is valid by now.
            r_leds  <= bus.dado_mem;
            r_timer <= '0;
            r_state <= ACESO;
          end
          ACESO: begin
            if (r_timer == ON_LAST) begin
              r_leds  <= '0;
              r_timer <= '0;
              r_state <= APAGADO;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          APAGADO: begin
            if (r_timer == OFF_LAST) begin
              r_timer <= '0;
              if (r_endereco == r_limite) begin
                r_state  <= FIM;
                r_pronto <= 1'b1;
              end else begin
                r_endereco <= r_endereco + 1'b1;
                r_state    <= CARREGA;
              end
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          FIM: begin
            r_endereco <= '0;
            r_state    <= OCIOSO;
            r_ativo    <= 1'b0;
          end
          default: begin
            r_state    <= OCIOSO;
            r_timer    <= '0;
            r_endereco <= '0;
            r_leds     <= '0;
            r_ativo    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.endereco  = r_endereco;
  assign bus.leds      = r_leds;
  assign bus.ativo     = r_ativo;
  assign bus.pronto    = r_pronto;
  assign bus.db_estado = r_state;

endmodule
